// File: rtl/hog_cell_feeder.sv
// hog_cell_feeder: streams a 320x240 frame as 8x8 cells, each packed with its one-pixel border.
// Build option: define HOG_FEED_ZERO_PAD_EN to zero out-of-frame border pixels (default replicates the edge).
module hog_cell_feeder #(
    parameter int PIX_W   = 8,
    parameter int CELL    = 8,
    parameter int CELLS_X = 40,
    parameter int CELLS_Y = 30,
    parameter int MEM_AW  = 14,
    parameter int ADDR_W  = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            request,
    output logic [MEM_AW-1:0]               mem_addr,
    output logic                            mem_rd,
    input  logic [CELL*PIX_W-1:0]           mem_rdata,
    output logic [(CELL*CELL+4*CELL)*PIX_W-1:0] o_data,
    output logic                            ready,
    output logic [ADDR_W-1:0]               cell_addr,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int WIN_PIX    = CELL*CELL + 4*CELL;
    localparam int TOP_BASE   = CELL*CELL;
    localparam int LEFT_BASE  = TOP_BASE + CELL;
    localparam int RIGHT_BASE = LEFT_BASE + CELL;
    localparam int BOT_BASE   = RIGHT_BASE + CELL;
    localparam int TOP_SLOT   = CELL;
    localparam int BOT_SLOT   = CELL + 1;
    localparam int LEFT_SLOT  = CELL + 2;
    localparam int RIGHT_SLOT = 2*CELL + 2;
    localparam int LAST_SLOT  = 3*CELL + 1;
    localparam int LAST_CELL  = CELLS_X*CELLS_Y - 1;
    localparam int CX_W       = $clog2(CELLS_X);
    localparam int CY_W       = $clog2(CELLS_Y);
`ifdef HOG_FEED_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FETCH, CAPT, EMIT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [4:0]                 issue_q, issue_d;
    logic [4:0]                 prev_slot_q, prev_slot_d;
    logic                       prev_vld_q, prev_vld_d;
    logic                       prev_rd_q, prev_rd_d;
    logic [CX_W-1:0]            cx_q, cx_d;
    logic [CY_W-1:0]            cy_q, cy_d;
    logic [ADDR_W-1:0]          cell_q, cell_d;
    logic                       busy_q, busy_d;
    logic [MEM_AW-1:0]          mem_addr_q, mem_addr_d;
    logic                       mem_rd_q, mem_rd_d;
    logic [WIN_PIX*PIX_W-1:0]   win_q, win_d;
    logic [WIN_PIX*PIX_W-1:0]   o_data_q, o_data_d;

    logic                       issue_en;
    logic [4:0]                 issue_slot;
    logic [CX_W-1:0]            issue_cx;
    logic [CY_W-1:0]            issue_cy;
    logic [MEM_AW:0]            issue_info;
    int                         ps;

    // Returns {in_frame, word_address} for one of the 26 fetch slots of cell (cx, cy).
    function automatic logic [MEM_AW:0] slot_addr(input logic [4:0] slot,
                                                  input logic [CX_W-1:0] cx,
                                                  input logic [CY_W-1:0] cy);
        int   s, row, col;
        logic ok;
        s   = int'(slot);
        row = int'(cy) * CELL;
        col = int'(cx);
        ok  = 1'b1;
        if (s < TOP_SLOT) begin
            row = row + s;
        end else if (s == TOP_SLOT) begin
            row = row - 1;
            ok  = (cy != '0);
        end else if (s == BOT_SLOT) begin
            row = row + CELL;
            ok  = (int'(cy) < CELLS_Y - 1);
        end else if (s < RIGHT_SLOT) begin
            row = row + s - LEFT_SLOT;
            col = col - 1;
            ok  = (cx != '0);
        end else begin
            row = row + s - RIGHT_SLOT;
            col = col + 1;
            ok  = (int'(cx) < CELLS_X - 1);
        end
        return {ok, MEM_AW'(row*CELLS_X + col)};
    endfunction

    function automatic logic [PIX_W-1:0] pad_pix(input logic [PIX_W-1:0] edge_val);
        return ZERO_PAD ? '0 : edge_val;
    endfunction

    // Each return is written into the window the cycle after its slot was issued; pads use
    // cell pixels, which are always captured before any border slot comes back.
    always_comb begin
        win_d = win_q;
        ps    = int'(prev_slot_q);
        if (prev_vld_q) begin
            if (ps < TOP_SLOT) begin
                for (int i = 0; i < CELL; i++)
                    win_d[(ps*CELL + i)*PIX_W +: PIX_W] = mem_rdata[i*PIX_W +: PIX_W];
            end else if (ps == TOP_SLOT) begin
                for (int i = 0; i < CELL; i++)
                    win_d[(TOP_BASE + i)*PIX_W +: PIX_W] = prev_rd_q ?
                        mem_rdata[i*PIX_W +: PIX_W] : pad_pix(win_q[i*PIX_W +: PIX_W]);
            end else if (ps == BOT_SLOT) begin
                for (int i = 0; i < CELL; i++)
                    win_d[(BOT_BASE + i)*PIX_W +: PIX_W] = prev_rd_q ?
                        mem_rdata[i*PIX_W +: PIX_W] :
                        pad_pix(win_q[((CELL-1)*CELL + i)*PIX_W +: PIX_W]);
            end else if (ps < RIGHT_SLOT) begin
                win_d[(LEFT_BASE + ps - LEFT_SLOT)*PIX_W +: PIX_W] = prev_rd_q ?
                    mem_rdata[(CELL-1)*PIX_W +: PIX_W] :
                    pad_pix(win_q[(ps - LEFT_SLOT)*CELL*PIX_W +: PIX_W]);
            end else begin
                win_d[(RIGHT_BASE + ps - RIGHT_SLOT)*PIX_W +: PIX_W] = prev_rd_q ?
                    mem_rdata[PIX_W-1:0] :
                    pad_pix(win_q[((ps - RIGHT_SLOT)*CELL + CELL - 1)*PIX_W +: PIX_W]);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        cell_d      = cell_q;
        busy_d      = busy_q;
        o_data_d    = o_data_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        prev_vld_d  = (state_q == FETCH);
        prev_slot_d = issue_q;
        prev_rd_d   = mem_rd_q;
        issue_en    = 1'b0;
        issue_slot  = issue_q;
        issue_cx    = cx_q;
        issue_cy    = cy_q;
        issue_info  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cell_d   = '0;
                    cx_d     = '0;
                    cy_d     = '0;
                    busy_d   = 1'b1;
                    issue_d  = '0;
                    issue_en = 1'b1;
                    issue_slot = '0;
                    issue_cx = '0;
                    issue_cy = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (issue_q == 5'(LAST_SLOT)) begin
                    state_d = CAPT;
                end else begin
                    issue_d    = issue_q + 5'd1;
                    issue_en   = 1'b1;
                    issue_slot = issue_q + 5'd1;
                end
            end
            CAPT: begin
                o_data_d = win_d;
                state_d  = EMIT;
            end
            EMIT: begin
                if (request) begin
                    if (cell_q == ADDR_W'(LAST_CELL)) begin
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        cell_d = cell_q + 1'b1;
                        if (cx_q == CX_W'(CELLS_X - 1)) begin
                            cx_d = '0;
                            cy_d = cy_q + 1'b1;
                        end else begin
                            cx_d = cx_q + 1'b1;
                        end
                        issue_d    = '0;
                        issue_en   = 1'b1;
                        issue_slot = '0;
                        issue_cx   = cx_d;
                        issue_cy   = cy_d;
                        state_d    = FETCH;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (issue_en) begin
            issue_info = slot_addr(issue_slot, issue_cx, issue_cy);
            mem_rd_d   = issue_info[MEM_AW];
            if (issue_info[MEM_AW])
                mem_addr_d = issue_info[MEM_AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            issue_q     <= '0;
            prev_slot_q <= '0;
            prev_vld_q  <= 1'b0;
            prev_rd_q   <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            cell_q      <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            win_q       <= '0;
            o_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            prev_slot_q <= prev_slot_d;
            prev_vld_q  <= prev_vld_d;
            prev_rd_q   <= prev_rd_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            cell_q      <= cell_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            win_q       <= win_d;
            o_data_q    <= o_data_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign o_data     = o_data_q;
    assign ready      = (state_q == EMIT) && request;
    assign cell_addr  = cell_q;
    assign busy       = busy_q;
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_hog_cell_feeder.sv
// tb_hog_cell_feeder: frame-memory model plus a pixel-coordinate reference of every cell window.
module tb_hog_cell_feeder;
    localparam int CX = 40;
    localparam int W  = 320;
    localparam int H  = 240;
    localparam int NCELL = 1200;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         request = 1'b0;
    logic [13:0]  mem_addr;
    logic         mem_rd;
    logic [63:0]  mem_rdata;
    logic [767:0] o_data;
    logic         ready;
    logic [10:0]  cell_addr;
    logic         busy;
    logic         frame_done;

    hog_cell_feeder dut (
        .clk(clk), .rst(rst), .start(start), .request(request),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .o_data(o_data), .ready(ready), .cell_addr(cell_addr),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0] frame_mem [0:H-1][0:W-1];
    int tests_run = 0;
    int tests_failed = 0;
    int rd_cnt = 0, oob_cnt = 0, rdy_cnt = 0, done_cnt = 0;
    int rd_base, total;

    function automatic logic [63:0] mem_word(input logic [13:0] a);
        logic [63:0] w;
        int ai, row, c;
        ai = int'(a);
        if (ai >= CX*H) return {$urandom, $urandom};
        row = ai / CX;
        c   = ai % CX;
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = frame_mem[row][c*8 + j];
        return w;
    endfunction

    // Memory answers one cycle after the strobe; idle cycles return garbage.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_word(mem_addr);
        else        mem_rdata <= {$urandom, $urandom};
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_rd && int'(mem_addr) >= CX*H) oob_cnt <= oob_cnt + 1;
        if (ready) rdy_cnt <= rdy_cnt + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [767:0] model_win(input int n);
        logic [767:0] w;
        int x0, y0;
        bit zp;
`ifdef HOG_FEED_ZERO_PAD_EN
        zp = 1'b1;
`else
        zp = 1'b0;
`endif
        x0 = (n % CX) * 8;
        y0 = (n / CX) * 8;
        w  = '0;
        for (int k = 0; k < 64; k++) w[k*8 +: 8] = frame_mem[y0 + k/8][x0 + k%8];
        for (int i = 0; i < 8; i++) begin
            w[(64+i)*8 +: 8] = (y0 > 0)     ? frame_mem[y0-1][x0+i] : (zp ? 8'h00 : frame_mem[y0][x0+i]);
            w[(72+i)*8 +: 8] = (x0 > 0)     ? frame_mem[y0+i][x0-1] : (zp ? 8'h00 : frame_mem[y0+i][x0]);
            w[(80+i)*8 +: 8] = (x0 + 8 < W) ? frame_mem[y0+i][x0+8] : (zp ? 8'h00 : frame_mem[y0+i][x0+7]);
            w[(88+i)*8 +: 8] = (y0 + 8 < H) ? frame_mem[y0+8][x0+i] : (zp ? 8'h00 : frame_mem[y0+7][x0+i]);
        end
        return w;
    endfunction

    function automatic int exp_reads(input int n);
        int cx, cy;
        cx = n % CX;
        cy = n / CX;
        return 8 + int'(cy > 0) + int'(cy < 29) + 8*int'(cx > 0) + 8*int'(cx < 39);
    endfunction

    task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_int({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk_int({tag, "_mem_rd"}, int'(mem_rd), 0);
        chk({tag, "_o_data"}, o_data, '0);
        chk_int({tag, "_ready"}, int'(ready), 0);
        chk_int({tag, "_cell_addr"}, int'(cell_addr), 0);
        chk_int({tag, "_busy"}, int'(busy), 0);
        chk_int({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    task automatic begin_frame();
        @(posedge clk); #1;
        start   = 1'b1;
        request = 1'b1;
        rd_base = rd_cnt;
        total   = 0;
        @(negedge clk);
    endtask

    // Advances cycle by cycle until ready; request is low for `hold` cycles once EMIT is due.
    task automatic run_cell(input int n, input int hold, input bit rnd_req, input int start_at);
        logic [767:0] exp;
        int lat;
        exp = model_win(n);
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            start = (lat == start_at);
            if (lat < 28) request = rnd_req ? 1'($urandom_range(0, 1)) : 1'b1;
            else          request = (lat >= 28 + hold);
            @(negedge clk);
            if (hold > 0 && lat >= 28 && lat < 28 + hold) begin
                chk($sformatf("cell%0d_hold_data", n), o_data, exp);
                chk_int($sformatf("cell%0d_hold_rd", n), int'(mem_rd), 0);
                chk_int($sformatf("cell%0d_hold_ready", n), int'(ready), 0);
            end
            if (ready || lat >= 28 + hold + 8) break;
        end
        total += lat;
        chk_int($sformatf("cell%0d_latency", n), lat, 28 + hold);
        chk_int($sformatf("cell%0d_cell_addr", n), int'(cell_addr), n);
        chk($sformatf("cell%0d_data", n), o_data, exp);
        chk_int($sformatf("cell%0d_reads", n), rd_cnt - rd_base, exp_reads(n));
        rd_base = rd_cnt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [767:0] e;
        int rdy0, done0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                frame_mem[y][x] = 8'((x + 2*y) % 256);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Frame 1: ramp image, no backpressure, spurious start during cell 300.
        rdy0  = rdy_cnt;
        done0 = done_cnt;
        begin_frame();
        for (int n = 0; n < NCELL; n++) begin
            run_cell(n, 0, 1'b0, (n == 300) ? 5 : -1);
            if (n == 0) begin
                e = model_win(0);
                chk("c0_top", o_data[64*8 +: 64], e[64*8 +: 64]);
                chk("c0_left", o_data[72*8 +: 64], e[72*8 +: 64]);
            end
            if (n == 41) begin
                chk_int("c41_p0", int'(o_data[0 +: 8]), 24);
                chk_int("c41_p64", int'(o_data[64*8 +: 8]), 22);
                chk_int("c41_p72", int'(o_data[72*8 +: 8]), 23);
                chk_int("c41_p80", int'(o_data[80*8 +: 8]), 32);
                chk_int("c41_p95", int'(o_data[95*8 +: 8]), 47);
                chk_int("c41_busy", int'(busy), 1);
            end
            if (n == NCELL - 1) begin
                e = model_win(NCELL - 1);
                chk("c1199_right_bottom", o_data[80*8 +: 128], e[80*8 +: 128]);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk_int("frame_done_pulse", int'(frame_done), 1);
        chk_int("frame_done_busy", int'(busy), 0);
        chk_int("frame_done_cycle", total + 1, 33601);
        @(posedge clk); #1;
        @(negedge clk);
        chk_int("frame_done_one_cycle", int'(frame_done), 0);
        chk_int("ready_pulses", rdy_cnt - rdy0, NCELL);
        chk_int("frame_done_pulses", done_cnt - done0, 1);

        // Frame 2: random image, random request during fetch, random backpressure.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                frame_mem[y][x] = 8'($urandom);
        begin_frame();
        for (int n = 0; n < 60; n++)
            run_cell(n, (n == 41) ? 10 : int'($urandom_range(0, 3)), 1'b1, -1);

        // Abandon frame 2 with a reset, then reset again partway through cell 5 of a new frame.
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        begin_frame();
        for (int n = 0; n < 5; n++) run_cell(n, 0, 1'b0, -1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
        end
        chk_int("cell5_fetch_busy", int'(busy), 1);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(posedge clk); #1; rst = 1'b1;
        begin_frame();
        run_cell(0, 0, 1'b0, -1);
        run_cell(1, 0, 1'b0, -1);

        chk_int("oob_reads", oob_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
